// File: rtl/byte_striping_n.sv
// Round-robin byte striper: gathers valid bytes into a stripe of N lanes and emits all lanes at once.
// Optional STRIPE_PAD_EN pads flushed stripes with 8'hBC and adds the pad_mask output.
module byte_striping_n #(
   parameter  int DATA_W = 8,
   parameter  int LANES  = 4,
   localparam int LW     = $clog2(LANES) + 1
) (
   input  logic                    clk_2f,
   input  logic                    reset,
   input  logic                    valid_in,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    flush,
   input  logic [LW-1:0]           lanes_active,
   output logic [LANES*DATA_W-1:0] lane_data,
   output logic [LANES-1:0]        lane_valid,
`ifdef STRIPE_PAD_EN
   output logic [LANES-1:0]        pad_mask,
`endif
   output logic                    partial
);

   localparam int PW = $clog2(LANES);
   localparam logic [DATA_W-1:0] PAD_BYTE = DATA_W'(8'hBC);

   logic [PW-1:0]           r_ptr;
   logic [LW-1:0]           r_n;
   logic [DATA_W-1:0]       r_shadow [LANES];
   logic [LANES*DATA_W-1:0] r_lane_data;
   logic [LANES-1:0]        r_lane_valid;
   logic [LANES-1:0]        r_pad_mask;

   logic [LW-1:0]           w_n_req;
   logic [LW-1:0]           w_n;
   logic [LW-1:0]           w_fill;
   logic                    w_emit;
   logic [DATA_W-1:0]       w_shadow [LANES];
   logic [LANES*DATA_W-1:0] w_data;
   logic [LANES-1:0]        w_valid;
   logic [LANES-1:0]        w_pad;

   // Lane count only takes effect on the first byte of a stripe; out-of-range requests mean all lanes.
   always_comb begin
      w_n_req = (lanes_active == '0 || lanes_active > LW'(LANES)) ? LW'(LANES) : lanes_active;
      w_n     = (valid_in && r_ptr == '0) ? w_n_req : r_n;
      w_fill  = LW'(r_ptr) + LW'(valid_in);
      w_emit  = (valid_in && w_fill == w_n) || (flush && w_fill != '0);
      w_shadow = r_shadow;
      if (valid_in)
         w_shadow[r_ptr] = data_in;
   end

   always_comb begin
      w_data  = '0;
      w_valid = '0;
      w_pad   = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (LW'(i) < w_fill) begin
            w_data[i*DATA_W +: DATA_W] = w_shadow[i];
            w_valid[i]                 = 1'b1;
         end
`ifdef STRIPE_PAD_EN
         else if (LW'(i) < w_n) begin
            w_data[i*DATA_W +: DATA_W] = PAD_BYTE;
            w_valid[i]                 = 1'b1;
            w_pad[i]                   = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
         r_ptr        <= '0;
         r_n          <= LW'(LANES);
         r_lane_data  <= '0;
         r_lane_valid <= '0;
         r_pad_mask   <= '0;
         for (int unsigned i = 0; i < LANES; i++)
            r_shadow[i] <= '0;
      end else begin
         r_shadow     <= w_shadow;
         r_ptr        <= w_emit ? '0 : PW'(w_fill);
         if (valid_in && r_ptr == '0)
            r_n <= w_n_req;
         r_lane_valid <= w_emit ? w_valid : '0;
         r_pad_mask   <= w_emit ? w_pad : '0;
         if (w_emit)
            r_lane_data <= w_data;
      end
   end

   assign lane_data  = r_lane_data;
   assign lane_valid = r_lane_valid;
   assign partial    = (r_ptr != '0);
`ifdef STRIPE_PAD_EN
   assign pad_mask   = r_pad_mask;
`else
   logic w_unused_pad;
   assign w_unused_pad = ^{r_pad_mask, w_pad};
`endif

endmodule

// File: tb/tb_byte_striping_n.sv
// Self-checking bench for byte_striping_n: directed plan steps followed by random traffic,
// compared against a queue-based stripe model.
module tb_byte_striping_n;

   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int LW     = $clog2(LANES) + 1;

   logic                    clk_2f = 1'b0;
   logic                    reset;
   logic                    valid_in;
   logic [DATA_W-1:0]       data_in;
   logic                    flush;
   logic [LW-1:0]           lanes_active;
   logic [LANES*DATA_W-1:0] lane_data;
   logic [LANES-1:0]        lane_valid;
   logic                    partial;
`ifdef STRIPE_PAD_EN
   logic [LANES-1:0]        pad_mask;
`endif

   int errors = 0;
   int checks = 0;

   logic [LANES*DATA_W-1:0] m_data;
   logic [LANES-1:0]        m_valid;
   logic [LANES-1:0]        m_pad;
   logic [DATA_W-1:0]       q[$];
   int                      n_lat;

   byte_striping_n #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk_2f       (clk_2f),
      .reset        (reset),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .flush        (flush),
      .lanes_active (lanes_active),
      .lane_data    (lane_data),
      .lane_valid   (lane_valid),
`ifdef STRIPE_PAD_EN
      .pad_mask     (pad_mask),
`endif
      .partial      (partial)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_data  = '0;
      m_valid = '0;
      m_pad   = '0;
      n_lat   = LANES;
   endtask

   // Stripe model: bytes collect in a queue; a stripe leaves when the queue reaches N or on flush.
   task automatic model(input logic v, input logic [7:0] d, input logic f, input logic [LW-1:0] la);
      int n_req;
      m_valid = '0;
      m_pad   = '0;
      if (v) begin
         if (q.size() == 0) begin
            n_req = int'(la);
            n_lat = (n_req == 0 || n_req > LANES) ? LANES : n_req;
         end
         q.push_back(d);
      end
      if ((v && q.size() == n_lat) || (f && q.size() != 0)) begin
         m_data = '0;
         for (int i = 0; i < n_lat; i++) begin
            if (i < q.size()) begin
               m_data[i*DATA_W +: DATA_W] = q[i];
               m_valid[i] = 1'b1;
            end
`ifdef STRIPE_PAD_EN
            else begin
               m_data[i*DATA_W +: DATA_W] = 8'hBC;
               m_valid[i] = 1'b1;
               m_pad[i]   = 1'b1;
            end
`endif
         end
         q.delete();
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".data"},    64'(lane_data),  64'(m_data));
      chk({tag, ".valid"},   64'(lane_valid), 64'(m_valid));
      chk({tag, ".partial"}, 64'(partial),    64'(q.size() != 0));
`ifdef STRIPE_PAD_EN
      chk({tag, ".pad"},     64'(pad_mask),   64'(m_pad));
`endif
   endtask

   task automatic step(input string tag, input logic v, input logic [7:0] d,
                       input logic f, input logic [LW-1:0] la);
      valid_in     = v;
      data_in      = d;
      flush        = f;
      lanes_active = la;
      @(posedge clk_2f);
      #1;
      model(v, d, f, la);
      valid_in = 1'b0;
      flush    = 1'b0;
      check_outputs(tag);
   endtask

   initial begin
      reset        = 1'b1;
      valid_in     = 1'b0;
      data_in      = '0;
      flush        = 1'b0;
      lanes_active = LW'(4);
      model_reset();
      repeat (2) @(posedge clk_2f);
      #1;
      check_outputs("reset");
      reset = 1'b0;

      // Full 4-lane stripe
      step("s1_ff", 1'b1, 8'hFF, 1'b0, 3'd4);
      step("s1_ee", 1'b1, 8'hEE, 1'b0, 3'd4);
      step("s1_dd", 1'b1, 8'hDD, 1'b0, 3'd4);
      step("s1_cc", 1'b1, 8'hCC, 1'b0, 3'd4);
      chk("s1_word", 64'(lane_data), 64'h0000_0000_CCDD_EEFF);
      step("s1_after", 1'b0, 8'h00, 1'b0, 3'd4);

      // Idle cycles inside a stripe
      step("s2_03", 1'b1, 8'h03, 1'b0, 3'd4);
      step("s2_i0", 1'b0, 8'h5A, 1'b0, 3'd4);
      step("s2_i1", 1'b0, 8'hA5, 1'b0, 3'd4);
      step("s2_04", 1'b1, 8'h04, 1'b0, 3'd4);
      step("s2_07", 1'b1, 8'h07, 1'b0, 3'd4);
      step("s2_08", 1'b1, 8'h08, 1'b0, 3'd4);
      chk("s2_word", 64'(lane_data), 64'h0000_0000_0807_0403);

      // Two-lane stripes; mid-stripe lane count change ignored
      step("s3_11", 1'b1, 8'h11, 1'b0, 3'd2);
      step("s3_22", 1'b1, 8'h22, 1'b0, 3'd4);
      chk("s3_word0", 64'(lane_data), 64'h0000_0000_0000_2211);
      step("s3_33", 1'b1, 8'h33, 1'b0, 3'd2);
      step("s3_44", 1'b1, 8'h44, 1'b0, 3'd4);
      chk("s3_valid1", 64'(lane_valid), 64'h3);

      // Flush of a partial stripe, flush with concurrent byte, no-op flush
      step("s4_a1", 1'b1, 8'hA1, 1'b0, 3'd4);
      step("s4_a2", 1'b1, 8'hA2, 1'b0, 3'd4);
      step("s4_fl", 1'b0, 8'h00, 1'b1, 3'd4);
      step("s4_a1b", 1'b1, 8'hA1, 1'b0, 3'd4);
      step("s4_a2b", 1'b1, 8'hA2, 1'b0, 3'd4);
      step("s4_a3f", 1'b1, 8'hA3, 1'b1, 3'd4);
      step("s4_noop", 1'b0, 8'h00, 1'b1, 3'd4);
      step("s4_full", 1'b1, 8'h91, 1'b0, 3'd1);
      step("s4_ovr", 1'b1, 8'h92, 1'b0, 3'd0);
      step("s4_ovr2", 1'b1, 8'h93, 1'b1, 3'd7);

      // Asynchronous reset in the middle of a stripe
      step("s5_55", 1'b1, 8'h55, 1'b0, 3'd4);
      step("s5_66", 1'b1, 8'h66, 1'b0, 3'd4);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("s5_rst");
      #2;
      reset = 1'b0;
      step("s5_01", 1'b1, 8'h01, 1'b0, 3'd4);
      step("s5_02", 1'b1, 8'h02, 1'b0, 3'd4);
      step("s5_03", 1'b1, 8'h03, 1'b0, 3'd4);
      step("s5_04", 1'b1, 8'h04, 1'b0, 3'd4);
      chk("s5_word", 64'(lane_data), 64'h0000_0000_0403_0201);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         step("rnd", ($urandom_range(0, 9) < 7), 8'($urandom),
              ($urandom_range(0, 9) == 0), LW'($urandom_range(0, 7)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
